// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// One transaction in flight: IDLE (arbitrate/accept) -> EXEC -> RESP -> IDLE.
module alu_req_scheduler #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_cout,
  output logic              resp_zero,
  output logic              resp_overflow,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic [OP_W-1:0]   alu_opcode_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [DATA_W-1:0] resp_result_q;
  logic              resp_cout_q, resp_zero_q, resp_overflow_q;
  logic              accept;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_d     = state_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = req0_valid & ~(req1_valid & ~last_grant_q);
        req1_ready = req1_valid & ~(req0_valid & last_grant_q);
        if (req0_ready || req1_ready) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req0_ready | req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      owner_q         <= 1'b0;
      alu_opcode_q    <= '0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      resp_result_q   <= '0;
      resp_cout_q     <= 1'b0;
      resp_zero_q     <= 1'b0;
      resp_overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= req1_ready;
        last_grant_q <= req1_ready;
        alu_opcode_q <= req1_ready ? req1_opcode : req0_opcode;
        alu_a_q      <= req1_ready ? req1_a : req0_a;
        alu_b_q      <= req1_ready ? req1_b : req0_b;
      end
      if (state_q == EXEC) begin
        resp_result_q   <= alu_result;
        resp_cout_q     <= alu_cout;
        resp_zero_q     <= alu_zero;
        resp_overflow_q <= alu_overflow;
      end
    end
  end

  assign alu_opcode    = alu_opcode_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign resp_result   = resp_result_q;
  assign resp_cout     = resp_cout_q;
  assign resp_zero     = resp_zero_q;
  assign resp_overflow = resp_overflow_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a small reference ALU attached.
module tb_alu_req_scheduler;

  typedef struct {
    int         who;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] expRes;
    logic       expCout;
    logic       expZero;
    logic       expOvf;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req0Valid, req0Ready, req1Valid, req1Ready;
  logic [3:0] req0Opcode, req0A, req0B, req1Opcode, req1A, req1B;
  logic       resp0Valid, resp0Ready, resp1Valid, resp1Ready;
  logic [3:0] respResult;
  logic       respCout, respZero, respOverflow;
  logic [3:0] aluOpcode, aluA, aluB, aluResult;
  logic       aluCout, aluZero, aluOverflow;
  logic       busy;
  logic [4:0] aluWide;

  int assertCount = 0;
  int failCount   = 0;

  alu_req_scheduler #(.DATA_W(4), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_opcode(req0Opcode),
    .req0_a(req0A), .req0_b(req0B),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_opcode(req1Opcode),
    .req1_a(req1A), .req1_b(req1B),
    .resp0_valid(resp0Valid), .resp0_ready(resp0Ready),
    .resp1_valid(resp1Valid), .resp1_ready(resp1Ready),
    .resp_result(respResult), .resp_cout(respCout), .resp_zero(respZero),
    .resp_overflow(respOverflow),
    .alu_opcode(aluOpcode), .alu_a(aluA), .alu_b(aluB),
    .alu_result(aluResult), .alu_cout(aluCout), .alu_zero(aluZero),
    .alu_overflow(aluOverflow),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 ADD, 1 SUB (cout = borrow), 2 AND, 3 OR, 4 XOR.
  always_comb begin
    aluWide     = '0;
    aluResult   = '0;
    aluCout     = 1'b0;
    aluOverflow = 1'b0;
    case (aluOpcode)
      4'd0: begin
        aluWide     = {1'b0, aluA} + {1'b0, aluB};
        aluResult   = aluWide[3:0];
        aluCout     = aluWide[4];
        aluOverflow = (aluA[3] == aluB[3]) && (aluResult[3] != aluA[3]);
      end
      4'd1: begin
        aluWide     = {1'b0, aluA} - {1'b0, aluB};
        aluResult   = aluWide[3:0];
        aluCout     = aluWide[4];
        aluOverflow = (aluA[3] != aluB[3]) && (aluResult[3] != aluA[3]);
      end
      4'd2: aluResult = aluA & aluB;
      4'd3: aluResult = aluA | aluB;
      4'd4: aluResult = aluA ^ aluB;
      default: aluResult = '0;
    endcase
    aluZero = (aluResult == 4'd0);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t makeVec(input int who, input logic [3:0] op, a, b, r,
                                   input logic c, z, v);
    vec_t t;
    t.who = who; t.op = op; t.a = a; t.b = b;
    t.expRes = r; t.expCout = c; t.expZero = z; t.expOvf = v;
    return t;
  endfunction

  // One full transaction on a single requester, checking every phase.
  task automatic applyStimulus(input vec_t v);
    int   waitCnt;
    logic rdy;
    if (v.who == 0) begin
      req0Valid = 1'b1; req0Opcode = v.op; req0A = v.a; req0B = v.b;
    end else begin
      req1Valid = 1'b1; req1Opcode = v.op; req1A = v.a; req1B = v.b;
    end
    #1;
    waitCnt = 0;
    rdy = (v.who == 0) ? req0Ready : req1Ready;
    while (!rdy && waitCnt < 10) begin
      cycle();
      #1;
      waitCnt++;
      rdy = (v.who == 0) ? req0Ready : req1Ready;
    end
    checkOutput("vecGrant", {31'd0, rdy}, 32'd1);
    cycle();
    req0Valid = 1'b0; req1Valid = 1'b0;
    req0Opcode = 4'hF; req0A = 4'hF; req0B = 4'hF;
    req1Opcode = 4'hF; req1A = 4'hF; req1B = 4'hF;
    #1;
    checkOutput("vecExecBusy", {31'd0, busy}, 32'd1);
    checkOutput("vecExecNoResp", {30'd0, resp1Valid, resp0Valid}, 32'd0);
    cycle();
    #1;
    checkOutput("vecRespValid", {30'd0, resp1Valid, resp0Valid}, (v.who == 0) ? 32'd1 : 32'd2);
    checkOutput("vecResult", {28'd0, respResult}, {28'd0, v.expRes});
    checkOutput("vecFlags", {29'd0, respCout, respZero, respOverflow},
                {29'd0, v.expCout, v.expZero, v.expOvf});
    if (v.who == 0) resp0Ready = 1'b1; else resp1Ready = 1'b1;
    cycle();
    resp0Ready = 1'b0; resp1Ready = 1'b0;
    #1;
    checkOutput("vecIdle", {31'd0, busy}, 32'd0);
  endtask

  vec_t       vecs[6];
  logic [3:0] rrOp[4], rrA[4], rrB[4], rrExp[4];

  initial begin
    int idx, respIdx, lastAcc, accCount;
    logic accepted;

    vecs[0] = makeVec(0, 4'd0, 4'd15, 4'd1, 4'd0,  1'b1, 1'b1, 1'b0);
    vecs[1] = makeVec(1, 4'd1, 4'd8,  4'd1, 4'd7,  1'b0, 1'b0, 1'b1);
    vecs[2] = makeVec(0, 4'd1, 4'd2,  4'd5, 4'd13, 1'b1, 1'b0, 1'b0);
    vecs[3] = makeVec(1, 4'd3, 4'd0,  4'd0, 4'd0,  1'b0, 1'b1, 1'b0);
    vecs[4] = makeVec(0, 4'd2, 4'd15, 4'd9, 4'd9,  1'b0, 1'b0, 1'b0);
    vecs[5] = makeVec(1, 4'd4, 4'd15, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0);
    rrOp[0] = 4'd2; rrA[0] = 4'd12; rrB[0] = 4'd10; rrExp[0] = 4'd8;
    rrOp[1] = 4'd3; rrA[1] = 4'd12; rrB[1] = 4'd3;  rrExp[1] = 4'd15;
    rrOp[2] = 4'd4; rrA[2] = 4'd9;  rrB[2] = 4'd9;  rrExp[2] = 4'd0;
    rrOp[3] = 4'd2; rrA[3] = 4'd6;  rrB[3] = 4'd7;  rrExp[3] = 4'd6;

    rst = 1'b1;
    req0Valid = 1'b0; req0Opcode = '0; req0A = '0; req0B = '0;
    req1Valid = 1'b0; req1Opcode = '0; req1A = '0; req1B = '0;
    resp0Ready = 1'b0; resp1Ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstResp", {30'd0, resp1Valid, resp0Valid}, 32'd0);
    checkOutput("rstRegs", {18'd0, aluOpcode, aluA, aluB, respResult}, 32'd0);
    checkOutput("rstFlags", {29'd0, respCout, respZero, respOverflow}, 32'd0);

    // Tie after reset: req0 first (ADD 7+1), then req1 (SUB 3-3) three clocks later.
    req0Valid = 1'b1; req0Opcode = 4'd0; req0A = 4'd7; req0B = 4'd1;
    req1Valid = 1'b1; req1Opcode = 4'd1; req1A = 4'd3; req1B = 4'd3;
    #1;
    checkOutput("tieReady", {30'd0, req1Ready, req0Ready}, 32'd1);
    cycle();
    req0Valid = 1'b0;
    #1;
    checkOutput("tieExecReady", {30'd0, req1Ready, req0Ready}, 32'd0);
    checkOutput("tieExecBusy", {31'd0, busy}, 32'd1);
    cycle();
    #1;
    checkOutput("addRespValid", {30'd0, resp1Valid, resp0Valid}, 32'd1);
    checkOutput("addResult", {28'd0, respResult}, 32'd8);
    checkOutput("addFlags", {29'd0, respCout, respZero, respOverflow}, 32'b001);
    checkOutput("addRespReq1Ready", {31'd0, req1Ready}, 32'd0);
    resp0Ready = 1'b1;
    cycle();
    resp0Ready = 1'b0;
    #1;
    checkOutput("secondGrant", {30'd0, req1Ready, req0Ready}, 32'd2);
    cycle();
    req1Valid = 1'b0;
    cycle();
    #1;
    checkOutput("subRespValid", {30'd0, resp1Valid, resp0Valid}, 32'd2);
    checkOutput("subResult", {28'd0, respResult}, 32'd0);
    checkOutput("subZeroOvf", {30'd0, respZero, respOverflow}, 32'b10);
    resp1Ready = 1'b1;
    cycle();
    resp1Ready = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Response back-pressure: req0 XOR 5^3 held in RESP while req1 waits.
    req0Valid = 1'b1; req0Opcode = 4'd4; req0A = 4'd5; req0B = 4'd3;
    #1;
    checkOutput("holdGrant", {31'd0, req0Ready}, 32'd1);
    cycle();
    req0Valid = 1'b0;
    req1Valid = 1'b1; req1Opcode = rrOp[0]; req1A = rrA[0]; req1B = rrB[0];
    cycle();
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("holdValid", {30'd0, resp1Valid, resp0Valid}, 32'd1);
      checkOutput("holdResult", {28'd0, respResult}, 32'd6);
      checkOutput("holdBusyReady", {30'd0, busy, req1Ready}, 32'b10);
      cycle();
    end
    resp0Ready = 1'b1;
    cycle();
    resp0Ready = 1'b0;

    // req1 alone and continuously valid: four accepts exactly three clocks apart.
    resp1Ready = 1'b1;
    idx = 0; respIdx = 0; lastAcc = -1; accCount = 0;
    for (int c = 0; c < 40 && respIdx < 4; c++) begin
      #1;
      if (resp1Valid) begin
        checkOutput("rrResult", {28'd0, respResult}, {28'd0, rrExp[respIdx]});
        checkOutput("rrZero", {31'd0, respZero}, {31'd0, rrExp[respIdx] == 4'd0});
        respIdx++;
      end
      accepted = req1Ready;
      if (accepted) begin
        if (lastAcc >= 0) checkOutput("rrSpacing", c - lastAcc, 32'd3);
        lastAcc = c;
        accCount++;
      end
      cycle();
      if (accepted) begin
        idx++;
        if (idx < 4) begin
          req1Opcode = rrOp[idx]; req1A = rrA[idx]; req1B = rrB[idx];
        end else begin
          req1Valid = 1'b0;
        end
      end
    end
    checkOutput("rrAccepts", accCount, 32'd4);
    checkOutput("rrResponses", respIdx, 32'd4);
    resp1Ready = 1'b0;
    cycle();

    // Reset during EXEC after req0 won: nothing returned, next tie goes to req0.
    req0Valid = 1'b1; req0Opcode = 4'd0; req0A = 4'd1; req0B = 4'd2;
    #1;
    checkOutput("midGrant", {31'd0, req0Ready}, 32'd1);
    cycle();
    req0Valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midExecBusy", {31'd0, busy}, 32'd1);
    cycle();
    rst = 1'b0;
    #1;
    checkOutput("midIdle", {31'd0, busy}, 32'd0);
    checkOutput("midRegs", {22'd0, aluA, aluB, resp1Valid, resp0Valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      #1;
      checkOutput("midNoResp", {30'd0, resp1Valid, resp0Valid}, 32'd0);
    end
    req0Valid = 1'b1; req1Valid = 1'b1;
    #1;
    checkOutput("midTie", {30'd0, req1Ready, req0Ready}, 32'd1);
    req0Valid = 1'b0; req1Valid = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
